// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS bus sequencer.
// State encoding, reset vector and default watchdog limit.
package mips_bus_pkg;

  typedef enum logic [2:0] {
    RST_STROBE,
    FETCH,
    SETTLE,
    DATA,
    COMMIT,
    HALT,
    ERROR
  } t_bus_state;

  localparam logic [31:0] RESET_VECTOR   = 32'hBFC00000;
  localparam int          WAIT_LIMIT_DEF = 255;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// Saturating wait-state counter for the bus watchdog.
// expired is high once the count has reached WAIT_LIMIT.
module bus_wait_timer
  import mips_bus_pkg::*;
#(
  parameter int WAIT_LIMIT = WAIT_LIMIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic count_en,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);

  logic [CW-1:0] r_count;

  // Count stalled request cycles; hold at the limit, zero on completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (count_en && (r_count != LIMIT)) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign expired = (r_count == LIMIT);

endmodule

// File: rtl/mips_bus_sequencer.sv
// Multi-cycle sequencer sharing one Avalon port between fetch and load/store.
// Drives the core's advance pulse and reset strobe; owns the bus watchdog.
module mips_bus_sequencer
  import mips_bus_pkg::*;
#(
  parameter int WAIT_LIMIT = WAIT_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_instr_address,
  input  logic [31:0] cpu_data_address,
  input  logic        cpu_data_read,
  input  logic        cpu_data_write,
  input  logic [31:0] cpu_data_out,
  input  logic        cpu_active,
  output logic [31:0] cpu_instr,
  output logic [31:0] cpu_data_in,
  output logic        cpu_clock_enable,
  output logic        cpu_reset,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest,
  output logic        bus_error,
  output logic [31:0] retired_count
);

  t_bus_state  r_state;
  t_bus_state  w_next;
  logic [31:0] r_instr;
  logic [31:0] r_data_in;
  logic [31:0] r_retired;

  logic w_expired;
  logic w_fetch_misalign;
  logic w_data_misalign;
  logic w_is_load;
  logic w_fetch_req;
  logic w_data_req;
  logic w_fetch_done;
  logic w_data_done;

  assign w_fetch_misalign = |cpu_instr_address[1:0];
  assign w_data_misalign  = |cpu_data_address[1:0];
  assign w_is_load        = cpu_data_read & ~cpu_data_write;

  assign w_fetch_req = (r_state == FETCH) & ~w_fetch_misalign & ~w_expired;
  assign w_data_req  = (r_state == DATA)
                     & (cpu_data_read | cpu_data_write)
                     & ~w_expired;

  assign w_fetch_done = w_fetch_req & ~mem_waitrequest;
  assign w_data_done  = w_data_req & ~mem_waitrequest;

  bus_wait_timer #(
    .WAIT_LIMIT(WAIT_LIMIT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .count_en((w_fetch_req | w_data_req) & mem_waitrequest),
    .clear   (w_fetch_done | w_data_done),
    .expired (w_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= RST_STROBE;
    else        r_state <= w_next;
  end

  // Next-state and bus/core outputs; requests are gated by the watchdog.
  always_comb begin
    w_next           = r_state;
    cpu_reset        = 1'b0;
    cpu_clock_enable = 1'b0;
    mem_address      = '0;
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    mem_writedata    = '0;
    bus_error        = 1'b0;
    unique case (r_state)
      RST_STROBE: begin
        cpu_reset        = 1'b1;
        cpu_clock_enable = reset;
        w_next           = FETCH;
      end
      FETCH: begin
        mem_address = word_align(cpu_instr_address);
        mem_read    = w_fetch_req;
        if (w_fetch_misalign || w_expired) w_next = ERROR;
        else if (!mem_waitrequest)         w_next = SETTLE;
      end
      SETTLE: begin
        if (cpu_data_read || cpu_data_write)
          w_next = w_data_misalign ? ERROR : DATA;
        else
          w_next = COMMIT;
      end
      DATA: begin
        mem_address = word_align(cpu_data_address);
        mem_read    = w_data_req & w_is_load;
        mem_write   = w_data_req & cpu_data_write;
        if (cpu_data_write) mem_writedata = cpu_data_out;
        if (w_expired)                          w_next = ERROR;
        else if (!w_data_req || !mem_waitrequest) w_next = COMMIT;
      end
      COMMIT: begin
        cpu_clock_enable = 1'b1;
        w_next           = cpu_active ? FETCH : HALT;
      end
      HALT: begin
        w_next = HALT;
      end
      ERROR: begin
        bus_error = 1'b1;
        w_next    = ERROR;
      end
      default: begin
        w_next = ERROR;
      end
    endcase
  end

  // Instruction/load latches update only on access completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr   <= '0;
      r_data_in <= '0;
    end else begin
      if (w_fetch_done)             r_instr   <= mem_readdata;
      if (w_data_done && w_is_load) r_data_in <= mem_readdata;
    end
  end

  // Retired instruction counter, free-running wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 r_retired <= '0;
    else if (r_state == COMMIT) r_retired <= r_retired + 32'd1;
  end

  assign cpu_instr      = r_instr;
  assign cpu_data_in    = r_data_in;
  assign retired_count  = r_retired;
  assign mem_byteenable = 4'hF;

endmodule

// File: tb/tb_mips_bus_sequencer.sv
// Directed bench for mips_bus_sequencer.
// Watchdog limit reduced to 4 for the stall test.
module tb_mips_bus_sequencer;
  import mips_bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_instr_address;
  logic [31:0] cpu_data_address;
  logic        cpu_data_read;
  logic        cpu_data_write;
  logic [31:0] cpu_data_out;
  logic        cpu_active;
  logic [31:0] cpu_instr;
  logic [31:0] cpu_data_in;
  logic        cpu_clock_enable;
  logic        cpu_reset;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_readdata;
  logic        mem_waitrequest;
  logic        bus_error;
  logic [31:0] retired_count;

  int n_cmp = 0;
  int n_err = 0;
  int cyc_n = 0;
  int t0;
  logic acc;

  always #5 clk = ~clk;

  mips_bus_sequencer #(
    .WAIT_LIMIT(4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .cpu_instr_address(cpu_instr_address),
    .cpu_data_address (cpu_data_address),
    .cpu_data_read    (cpu_data_read),
    .cpu_data_write   (cpu_data_write),
    .cpu_data_out     (cpu_data_out),
    .cpu_active       (cpu_active),
    .cpu_instr        (cpu_instr),
    .cpu_data_in      (cpu_data_in),
    .cpu_clock_enable (cpu_clock_enable),
    .cpu_reset        (cpu_reset),
    .mem_address      (mem_address),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_byteenable   (mem_byteenable),
    .mem_readdata     (mem_readdata),
    .mem_waitrequest  (mem_waitrequest),
    .bus_error        (bus_error),
    .retired_count    (retired_count)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc();
    cyc();
    @(negedge clk);
    reset = 1'b1;
    cyc();
  endtask

  initial begin
    reset             = 1'b0;
    cpu_instr_address = RESET_VECTOR;
    cpu_data_address  = '0;
    cpu_data_read     = 1'b0;
    cpu_data_write    = 1'b0;
    cpu_data_out      = '0;
    cpu_active        = 1'b1;
    mem_readdata      = '0;
    mem_waitrequest   = 1'b0;
    #2;
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_ce", 32'(cpu_clock_enable), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_instr", cpu_instr, 32'd0);
    chk("rst_data_in", cpu_data_in, 32'd0);
    chk("rst_retired", retired_count, 32'd0);
    chk("rst_bus_error", 32'(bus_error), 32'd0);
    cyc();
    cyc();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("strobe_reset", 32'(cpu_reset), 32'd1);
    chk("strobe_ce", 32'(cpu_clock_enable), 32'd1);
    chk("strobe_read", 32'(mem_read), 32'd0);
    cyc();
    chk("fetch_reset_drop", 32'(cpu_reset), 32'd0);
    chk("fetch_ce", 32'(cpu_clock_enable), 32'd0);
    chk("fetch_read", 32'(mem_read), 32'd1);
    chk("fetch_addr", mem_address, RESET_VECTOR);
    chk("byteenable", 32'(mem_byteenable), 32'hF);

    // addiu, zero wait
    mem_readdata = 32'h24020005;
    cyc();
    chk("alu_instr", cpu_instr, 32'h24020005);
    chk("settle_read", 32'(mem_read), 32'd0);
    chk("settle_ce", 32'(cpu_clock_enable), 32'd0);
    cyc();
    chk("alu_commit_ce", 32'(cpu_clock_enable), 32'd1);
    chk("alu_count_pre", retired_count, 32'd0);
    cyc();
    chk("alu_count", retired_count, 32'd1);
    chk("alu_ce_off", 32'(cpu_clock_enable), 32'd0);
    cpu_instr_address = 32'hBFC00004;
    mem_readdata      = 32'h24030007;
    #1;
    chk("fetch2_addr", mem_address, 32'hBFC00004);
    cyc();
    chk("alu2_settle_ce", 32'(cpu_clock_enable), 32'd0);
    cyc();
    chk("alu2_commit_ce", 32'(cpu_clock_enable), 32'd1);
    cyc();
    chk("alu2_count", retired_count, 32'd2);

    // lw with two wait states
    t0 = cyc_n;
    cpu_instr_address = 32'hBFC00008;
    mem_readdata      = 32'h8C021000;
    cyc();
    cpu_data_read    = 1'b1;
    cpu_data_address = 32'h00001000;
    mem_waitrequest  = 1'b1;
    mem_readdata     = 32'h0;
    cyc();
    chk("ld_read_w1", 32'(mem_read), 32'd1);
    chk("ld_addr_w1", mem_address, 32'h00001000);
    cyc();
    chk("ld_read_w2", 32'(mem_read), 32'd1);
    chk("ld_addr_w2", mem_address, 32'h00001000);
    cyc();
    chk("ld_addr_w3", mem_address, 32'h00001000);
    chk("ld_data_pre", cpu_data_in, 32'd0);
    mem_waitrequest = 1'b0;
    mem_readdata    = 32'hDEADBEEF;
    cyc();
    chk("ld_data_in", cpu_data_in, 32'hDEADBEEF);
    chk("ld_commit_ce", 32'(cpu_clock_enable), 32'd1);
    chk("ld_cycles", 32'(cyc_n - t0 + 1), 32'd6);
    cyc();
    chk("ld_count", retired_count, 32'd3);
    cpu_data_read = 1'b0;

    // sw, zero wait
    cpu_instr_address = 32'hBFC0000C;
    mem_readdata      = 32'hAC031004;
    cyc();
    cpu_data_write   = 1'b1;
    cpu_data_address = 32'h00001004;
    cpu_data_out     = 32'h12345678;
    cyc();
    chk("st_write", 32'(mem_write), 32'd1);
    chk("st_wdata", mem_writedata, 32'h12345678);
    chk("st_no_read", 32'(mem_read), 32'd0);
    chk("st_addr", mem_address, 32'h00001004);
    cyc();
    chk("st_write_drop", 32'(mem_write), 32'd0);
    chk("st_commit_ce", 32'(cpu_clock_enable), 32'd1);
    chk("st_data_in_keep", cpu_data_in, 32'hDEADBEEF);
    cyc();
    chk("st_count", retired_count, 32'd4);

    // misaligned store
    cpu_data_write    = 1'b0;
    cpu_instr_address = 32'hBFC00010;
    mem_readdata      = 32'hAC031002;
    cyc();
    cpu_data_write   = 1'b1;
    cpu_data_address = 32'h00001002;
    cyc();
    chk("mis_bus_error", 32'(bus_error), 32'd1);
    acc = 1'b0;
    for (int i = 0; i < 5; i++) begin
      acc = acc | mem_write | mem_read | cpu_clock_enable;
      cyc();
    end
    chk("mis_no_req", 32'(acc), 32'd0);
    chk("mis_sticky", 32'(bus_error), 32'd1);
    chk("mis_count", retired_count, 32'd4);

    // watchdog, stall forever
    cpu_data_write    = 1'b0;
    cpu_instr_address = RESET_VECTOR;
    mem_waitrequest   = 1'b1;
    do_reset();
    chk("wd_err_cleared", 32'(bus_error), 32'd0);
    chk("wd_count_cleared", retired_count, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("wd_read_held", 32'(mem_read), 32'd1);
      cyc();
    end
    chk("wd_read_drop", 32'(mem_read), 32'd0);
    cyc();
    chk("wd_bus_error", 32'(bus_error), 32'd1);
    chk("wd_no_read", 32'(mem_read), 32'd0);

    // halt at commit
    mem_waitrequest = 1'b0;
    do_reset();
    mem_readdata = 32'h24020001;
    cyc();
    cyc();
    cpu_active = 1'b0;
    chk("halt_commit_ce", 32'(cpu_clock_enable), 32'd1);
    cyc();
    chk("halt_count", retired_count, 32'd1);
    acc = 1'b0;
    for (int i = 0; i < 20; i++) begin
      acc = acc | mem_read | mem_write | cpu_clock_enable;
      cyc();
    end
    chk("halt_quiet", 32'(acc), 32'd0);

    // reset in the middle of a stalled fetch
    cpu_active      = 1'b1;
    mem_waitrequest = 1'b1;
    do_reset();
    chk("mid_read_on", 32'(mem_read), 32'd1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("mid_read_drop", 32'(mem_read), 32'd0);
    chk("mid_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("mid_ce", 32'(cpu_clock_enable), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    mem_waitrequest = 1'b0;
    #1;
    chk("mid_strobe_ce", 32'(cpu_clock_enable), 32'd1);
    cyc();
    chk("mid_refetch", 32'(mem_read), 32'd1);
    chk("mid_refetch_addr", mem_address, RESET_VECTOR);
    chk("mid_count", retired_count, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mips_bus_sequencer.md
# mips_bus_sequencer

Multi-cycle controller that shares a single Avalon-style memory port between the MIPS core's instruction fetch and its load/store traffic. It sequences each instruction as fetch, decode settle, optional data access, then commit. The core advances through its `clock_enable` input, which this block drives as a one-cycle pulse per retired instruction. It sits between the core's combinational `instr`/`data_*` interface and the memory bus, and owns the core's reset strobe and a bus watchdog.

## Interface
- `WAIT_LIMIT`, 255: maximum consecutive `mem_waitrequest` cycles on one access before a bus error is raised.
- `clk`  in  1  single system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cpu_instr_address`  in  32  fetch address from the core (its PC).
- `cpu_data_address`  in  32  load/store address from the core.
- `cpu_data_read`  in  1  core requests a load (combinational from `cpu_instr`).
- `cpu_data_write`  in  1  core requests a store.
- `cpu_data_out`  in  32  store data from the core.
- `cpu_active`  in  1  core running; low means halted.
- `cpu_instr`  out  32  registered instruction word presented to the core.
- `cpu_data_in`  out  32  registered load data presented to the core.
- `cpu_clock_enable`  out  1  one-cycle advance pulse to the core.
- `cpu_reset`  out  1  active-high synchronous reset strobe to the core.
- `mem_address`  out  32  word-aligned bus address.
- `mem_read`  out  1  bus read request.
- `mem_write`  out  1  bus write request.
- `mem_writedata`  out  32  bus write data.
- `mem_byteenable`  out  4  byte lanes; always 4'hF.
- `mem_readdata`  in  32  bus read data; valid in the cycle `mem_waitrequest` is low.
- `mem_waitrequest`  in  1  slave stall.
- `bus_error`  out  1  sticky error flag.
- `retired_count`  out  32  count of committed instructions.

## Operation
- **States:** `RST_STROBE`, `FETCH`, `SETTLE`, `DATA`, `COMMIT`, `HALT`, `ERROR`.
- **Asynchronous reset (`reset`=0):**
  - State becomes `RST_STROBE`.
  - `cpu_reset`=1 and all other outputs are 0 (`cpu_instr`, `cpu_data_in`, `retired_count`, and the timer included).
- **`RST_STROBE`:** one cycle with `cpu_reset`=1 and `cpu_clock_enable`=1, so the core clears its register file and loads its reset vector. Next state is `FETCH`.
- **`FETCH`:**
  - Drive `mem_read`=1 and `mem_address`=`cpu_instr_address`.
  - When `mem_waitrequest`=0, latch `mem_readdata` into `cpu_instr` and go to `SETTLE`.
- **`SETTLE`:** one cycle with no bus request, so the core's decode of the new `cpu_instr` stabilises. Then:
  - `cpu_data_read` or `cpu_data_write` high → `DATA`.
  - Otherwise → `COMMIT`.
- **`DATA`:**
  - Drive `mem_address`=`cpu_data_address`.
  - For a load, drive `mem_read`=1. For a store, drive `mem_write`=1 and `mem_writedata`=`cpu_data_out`.
  - If read and write are both high, the access is treated as a store.
  - On `mem_waitrequest`=0, a load latches `cpu_data_in`; then go to `COMMIT`.
- **`COMMIT`:**
  - `cpu_clock_enable`=1 for exactly one cycle and `retired_count` increments (wraps at 2^32).
  - Next state is `FETCH`, or `HALT` if `cpu_active`=0 in that cycle.
- **`HALT`:** no bus activity and `cpu_clock_enable`=0. Exit only by reset.
- **Alignment:**
  - A non-zero `[1:0]` on a fetch or data address, sampled on entry to `FETCH` or `DATA`, sends the block to `ERROR` without issuing the request.
  - `mem_address[1:0]` is always 2'b00.
- **Watchdog:**
  - The timer counts consecutive cycles with a request active and `mem_waitrequest`=1, and clears on each access completion.
  - When the count reaches `WAIT_LIMIT`, the request drops the same cycle and the state becomes `ERROR`.
- **`ERROR`:** `bus_error`=1, no requests, `cpu_clock_enable`=0. Exit only by reset.

## Timing
- **Request stability:** requests are Moore outputs of the state. Address, data and read/write are held constant while `mem_waitrequest`=1.
- **Bus protocol:** zero-latency read; at most one outstanding access.
- **Minimum cycles per instruction:** 3 (FETCH, SETTLE, COMMIT) with no data access; 4 with a data access and no wait states.
  - Each wait-state cycle adds 1.
- **Output stability:** `cpu_instr` and `cpu_data_in` change only on access completion, so both are stable across the `COMMIT` edge.
- **Reset during an access:** reset mid-access drops `mem_read`/`mem_write` asynchronously. No completion is recorded.
- **Slave completing immediately:** if the slave drives `mem_waitrequest`=0 in the first request cycle, the access completes in that cycle.

## Structure
- **Shared package `mips_bus_pkg`:**
  - the state enum `t_bus_state`;
  - the reset-vector constant 32'hBFC00000, used by the bench;
  - the default `WAIT_LIMIT`.
- **Sub-module `bus_wait_timer`:**
  - saturating counter with inputs `clk`, `reset`, `count_en`, `clear`;
  - output `expired`, asserted when the count equals `WAIT_LIMIT`.
- **FSM:** the sequencer FSM, the data latches and `retired_count` live in the top module.

## Test plan
- **Reset release:** release reset with zero-wait memory.
  - `cpu_reset` high for exactly 1 cycle with `cpu_clock_enable`=1.
  - First `mem_read` at 32'hBFC00000.
- **ALU instruction, no data access:** fetch `addiu` with zero wait states → `cpu_clock_enable` pulses every 3rd cycle and `retired_count`=1 after the first commit.
- **Load with wait states:**
  - Stimulus: `lw` at `cpu_data_address`=32'h00001000, 2 wait states, `mem_readdata`=32'hDEADBEEF.
  - Required: `cpu_data_in`=32'hDEADBEEF before commit; total 6 cycles; address stable throughout.
- **Store:** `sw` with `cpu_data_out`=32'h12345678 → `mem_write`=1 and `mem_writedata`=32'h12345678 for 1 cycle; `mem_read`=0 during the data phase.
- **Misalignment and watchdog:**
  - `cpu_data_address`=32'h00001002 → `bus_error`=1, no `mem_write` issued.
  - Separately, `WAIT_LIMIT`=4 with `mem_waitrequest` held high → `ERROR` after 4 cycles, and the request drops.
- **Halt and mid-access reset:**
  - `cpu_active` low at commit → `HALT`, no further requests over 20 cycles.
  - `reset` low mid-`FETCH` → `mem_read`=0 immediately, then the reset sequence replays.
